// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - staged FIR coefficient loader with atomic commit and registered sample path
// Optional COEF_CHECKSUM_EN adds an 8th checksum beat that gates the commit.
module fir_coef_loader #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             cfg_ready,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] Data_o,
  output logic [WIDTH-1:0] B0,
  output logic [WIDTH-1:0] B1,
  output logic [WIDTH-1:0] B2,
  output logic [WIDTH-1:0] B3,
  output logic [WIDTH-1:0] B4,
  output logic [WIDTH-1:0] B5,
  output logic [WIDTH-1:0] B6,
  output logic             busy,
  output logic             load_done,
  output logic             load_err
);

  localparam int            TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
`ifdef COEF_CHECKSUM_EN
  localparam logic [2:0]    LAST = 3'd7;
`else
  localparam logic [2:0]    LAST = 3'd6;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

  state_t          state_q;
  logic [2:0]      idx_q;
  logic [2:0]      idx_d;
  logic [TW-1:0]   timer_q;
  logic            cfg_ready_q;
  logic            load_done_q;
  logic            load_err_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] shadow_q [7];
  logic [WIDTH-1:0] coef_q   [7];
  logic            beat;
  logic            last_ok;

  // A restart pulse takes priority, so any beat in that cycle is dropped.
  assign beat  = cfg_valid & cfg_ready_q & (state_q == S_LOAD) & ~cfg_start;
  assign idx_d = (idx_q == LAST) ? idx_q : idx_q + 3'd1;

`ifdef COEF_CHECKSUM_EN
  logic [WIDTH-1:0] sum_d;
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 7; i++) sum_d = sum_d + shadow_q[i];
  end
  assign last_ok = (cfg_data == sum_d);
`else
  assign last_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      cfg_ready_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      for (int i = 0; i < 7; i++) coef_q[i] <= '0;
    end else begin
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            state_q     <= S_LOAD;
            idx_q       <= '0;
            timer_q     <= '0;
            cfg_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cfg_start) begin
            idx_q      <= '0;
            timer_q    <= '0;
            load_err_q <= 1'b1;
          end else if (beat) begin
            timer_q <= '0;
            if (idx_q == LAST) begin
              cfg_ready_q <= 1'b0;
              if (last_ok) begin
                state_q <= S_COMMIT;
              end else begin
                state_q    <= S_IDLE;
                load_err_q <= 1'b1;
              end
            end else begin
              idx_q <= idx_d;
            end
          end else if (timer_q == TMAX) begin
            state_q     <= S_IDLE;
            cfg_ready_q <= 1'b0;
            timer_q     <= '0;
            load_err_q  <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < 7; i++) coef_q[i] <= shadow_q[i];
          load_done_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Shadow taps are deliberately left out of reset; only a completed burst exposes them.
  always_ff @(posedge clk) begin
    if (Rst_n && beat && (idx_q != 3'd7)) shadow_q[idx_q] <= cfg_data;
  end

  always_ff @(posedge clk) begin
    if (!Rst_n) data_q <= '0;
    else        data_q <= sample_valid ? sample_i : '0;
  end

  assign cfg_ready = cfg_ready_q;
  assign busy      = (state_q != S_IDLE);
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign Data_o    = data_q;
  assign B0        = coef_q[0];
  assign B1        = coef_q[1];
  assign B2        = coef_q[2];
  assign B3        = coef_q[3];
  assign B4        = coef_q[4];
  assign B5        = coef_q[5];
  assign B6        = coef_q[6];

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb/tb_fir_coef_loader.sv - scoreboard bench for fir_coef_loader (honours COEF_CHECKSUM_EN)
module tb_fir_coef_loader;

  logic       clk = 1'b0;
  logic       Rst_n;
  logic       cfg_start;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       sample_valid;
  logic [7:0] sample_i;
  logic [7:0] Data_o;
  logic [7:0] B0, B1, B2, B3, B4, B5, B6;
  logic       busy;
  logic       load_done;
  logic       load_err;

  always #5 clk = ~clk;

  fir_coef_loader #(.WIDTH(8), .TIMEOUT(4)) dut (
    .clk(clk), .Rst_n(Rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .sample_valid(sample_valid),
    .sample_i(sample_i), .Data_o(Data_o), .B0(B0), .B1(B1), .B2(B2), .B3(B3),
    .B4(B4), .B5(B5), .B6(B6), .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_seen = 0;
  int          dir_idx = 0;
  int          err0;
  logic [55:0] cur_b = '0;
  logic [55:0] coef_sb [$];
  logic [7:0]  samp_sb [$];
  logic [7:0]  dir_val [3];
  logic        dir_vld [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic       sv;
    logic [7:0] si;
    if (Rst_n && dir_idx < 3) begin
      sv = dir_vld[dir_idx];
      si = dir_val[dir_idx];
      dir_idx++;
    end else begin
      sv = 1'($urandom_range(0, 1));
      si = 8'($urandom);
    end
    sample_valid = sv;
    sample_i     = si;
    samp_sb.push_back(!Rst_n ? 8'h00 : (sv ? si : 8'h00));
    @(posedge clk);
    #1;
    chk("data_o", 64'(Data_o), 64'(samp_sb.pop_front()));
    if (!Rst_n) begin
      cur_b = '0;
      coef_sb.delete();
    end
    if (load_done) begin
      chk("done_pending", 64'(coef_sb.size() != 0), 64'(1));
      if (coef_sb.size() != 0) cur_b = coef_sb.pop_front();
    end
    if (load_err) err_seen++;
    chk("done_err_excl", 64'(load_done & load_err), 64'(0));
    chk("coefs", 64'({B6, B5, B4, B3, B2, B1, B0}), 64'(cur_b));
  endtask

  task automatic start();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input int gap);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    while (!cfg_ready && n < 16) begin
      step();
      n++;
    end
    chk("ready_wait", 64'(n < 16), 64'(1));
    step();
    cfg_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic burst(input logic [55:0] c, input int gap, input logic bad);
    logic [7:0] s = '0;
    for (int i = 0; i < 7; i++) begin
`ifndef COEF_CHECKSUM_EN
      if (i == 6 && !bad) coef_sb.push_back(c);
`endif
      s = s + c[8*i +: 8];
      beat(c[8*i +: 8], (i == 6) ? 0 : gap);
    end
`ifdef COEF_CHECKSUM_EN
    if (!bad) coef_sb.push_back(c);
    beat(s + 8'(bad), 0);
`endif
  endtask

  task automatic wait_done();
    int n = 0;
    while (!load_done && n < 10) begin
      step();
      n++;
    end
    chk("done_seen", 64'(load_done), 64'(1));
    chk("busy_after_done", 64'(busy), 64'(0));
    step();
    chk("done_one_cycle", 64'(load_done), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    dir_val[0] = 8'h55; dir_vld[0] = 1'b1;
    dir_val[1] = 8'h33; dir_vld[1] = 1'b0;
    dir_val[2] = 8'hAA; dir_vld[2] = 1'b1;
    Rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    sample_valid = 1'b0; sample_i = '0;

    step();
    step();
    chk("rst_ready", 64'(cfg_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(load_done), 64'(0));
    chk("rst_err", 64'(load_err), 64'(0));
    Rst_n = 1'b1;

    // stray valid in IDLE must do nothing
    cfg_valid = 1'b1; cfg_data = 8'hFF;
    repeat (3) step();
    chk("idle_ready", 64'(cfg_ready), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    cfg_valid = 1'b0;

    start();
    chk("load_busy", 64'(busy), 64'(1));
    chk("load_ready", 64'(cfg_ready), 64'(1));
    burst({8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0, 1'b0);
    wait_done();
    chk("basic_no_err", 64'(err_seen), 64'(0));

    start();
    burst({8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10}, 3, 1'b0);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    wait_done();
    chk("commit_start_ignored", 64'(err_seen), 64'(0));

    err0 = err_seen;
    start();
    beat(8'h31, 0); beat(8'h32, 0); beat(8'h33, 0);
    repeat (3) step();
    chk("timeout_early", 64'(load_err), 64'(0));
    step();
    chk("timeout_err", 64'(load_err), 64'(1));
    chk("timeout_ready", 64'(cfg_ready), 64'(0));
    chk("timeout_busy", 64'(busy), 64'(0));
    step();
    chk("timeout_pulse", 64'(load_err), 64'(0));
    chk("timeout_count", 64'(err_seen - err0), 64'(1));

    err0 = err_seen;
    start();
    beat(8'd20, 0); beat(8'd21, 0);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'd99;
    step();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    chk("restart_err", 64'(load_err), 64'(1));
    chk("restart_busy", 64'(busy), 64'(1));
    chk("restart_ready", 64'(cfg_ready), 64'(1));
    burst({8'd26, 8'd25, 8'd24, 8'd23, 8'd22, 8'd21, 8'd20}, 0, 1'b0);
    wait_done();
    chk("restart_count", 64'(err_seen - err0), 64'(1));

`ifdef COEF_CHECKSUM_EN
    start();
    burst({8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0, 1'b0);
    wait_done();
    err0 = err_seen;
    start();
    burst({8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0, 1'b1);
    chk("csum_err", 64'(load_err), 64'(1));
    chk("csum_busy", 64'(busy), 64'(0));
    step();
    chk("csum_count", 64'(err_seen - err0), 64'(1));
`endif

    start();
    beat(8'h41, 0); beat(8'h42, 0); beat(8'h43, 0);
    Rst_n = 1'b0;
    step();
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ready", 64'(cfg_ready), 64'(0));
    chk("midrst_done", 64'(load_done), 64'(0));
    chk("midrst_err", 64'(load_err), 64'(0));
    Rst_n = 1'b1;
    step();

    start();
    burst({8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1}, 1, 1'b0);
    wait_done();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
